spdif_tx_sequencer: RTL and testbench

Controls the S/PDIF frame assembler. Sits between the left/right 20-bit sample FIFOs and the assembler's data/ready inputs. Gates transmission on start/stop commands and FIFO prefill, and serves one sample per subframe request, alternating L then R. Tracks the 192-frame channel-status block, stops only on block boundaries, and handles FIFO underrun.

---
 rtl/spdif_tx_sequencer.sv | 158 +++++++++++++++
 tb/tb_spdif_tx_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_tx_sequencer.sv
// Gates the L/R sample FIFOs into the S/PDIF assembler: one sample per req with 1-cycle latency, L then R.
// The assembler is never stalled; a starved req yields an underrun pulse. Define SPDIF_SEQ_HOLD_LAST_EN to repeat the last sample on underrun.
module spdif_tx_sequencer #(
   parameter int DATA_W           = 20,
   parameter int LEVEL_W          = 6,
   parameter int PREFILL          = 8,
   parameter int FRAMES_PER_BLOCK = 192
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [DATA_W-1:0]  l_data,
   input  logic               l_valid,
   input  logic [LEVEL_W-1:0] l_level,
   output logic               l_pop,
   input  logic [DATA_W-1:0]  r_data,
   input  logic               r_valid,
   input  logic [LEVEL_W-1:0] r_level,
   output logic               r_pop,
   input  logic               req,
   output logic [DATA_W-1:0]  sample,
   output logic               run_en,
   output logic               block_start,
   output logic [7:0]         frame_idx,
   output logic               underrun,
   output logic [15:0]        underrun_count
);

   localparam logic [7:0]         LAST_FRAME  = 8'(FRAMES_PER_BLOCK - 1);
   localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREFILL,
      S_RUN,
      S_STOPPING
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              ch_r;        // 0 = left, 1 = right
   logic [7:0]        frame_cnt;   // frame of the next sample to serve
   logic              serve;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] fill_data;
   logic              last_serve;
   logic              prefill_ok;
   logic              enter_prefill;

   assign serve         = req && ((state == S_RUN) || (state == S_STOPPING));
   assign sel_valid     = ch_r ? r_valid : l_valid;
   assign sel_data      = ch_r ? r_data : l_data;
   assign last_serve    = serve && (state == S_STOPPING) && ch_r && (frame_cnt == LAST_FRAME);
   assign prefill_ok    = (l_level >= PREFILL_LVL) && (r_level >= PREFILL_LVL);
   assign enter_prefill = (state == S_IDLE) && start && !stop;
   assign run_en        = (state == S_RUN) || (state == S_STOPPING);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // stop always takes priority over start and over a satisfied prefill
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (enter_prefill) begin
               state_nxt = S_PREFILL;
            end
         end
         S_PREFILL: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else if (prefill_ok) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_nxt = S_STOPPING;
            end
         end
         S_STOPPING: begin
            if (last_serve) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef SPDIF_SEQ_HOLD_LAST_EN
   logic [DATA_W-1:0] l_last;
   logic [DATA_W-1:0] r_last;

   always_ff @(posedge clk) begin
      if (rst || enter_prefill) begin
         l_last <= '0;
         r_last <= '0;
      end else if (serve && sel_valid) begin
         if (ch_r) begin
            r_last <= r_data;
         end else begin
            l_last <= l_data;
         end
      end
   end

   assign fill_data = ch_r ? r_last : l_last;
`else
   assign fill_data = '0;
`endif

   // Channel toggle and frame wrap bring the exit serve back to L / frame 0 on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_r           <= 1'b0;
         frame_cnt      <= '0;
         sample         <= '0;
         l_pop          <= 1'b0;
         r_pop          <= 1'b0;
         block_start    <= 1'b0;
         frame_idx      <= '0;
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else begin
         l_pop    <= 1'b0;
         r_pop    <= 1'b0;
         underrun <= 1'b0;
         if (serve) begin
            ch_r        <= ~ch_r;
            block_start <= !ch_r && (frame_cnt == 8'd0);
            frame_idx   <= last_serve ? 8'd0 : frame_cnt;
            if (ch_r) begin
               frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
            end
            if (sel_valid) begin
               sample <= sel_data;
               l_pop  <= !ch_r;
               r_pop  <= ch_r;
            end else begin
               sample   <= fill_data;
               underrun <= 1'b1;
               if (underrun_count != 16'hFFFF) begin
                  underrun_count <= underrun_count + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spdif_tx_sequencer.sv
// Bench for spdif_tx_sequencer: queue-modelled show-ahead FIFOs, expected outputs derived from the
// count of requests served since block start.
module tb_spdif_tx_sequencer;

   localparam int DATA_W  = 20;
   localparam int LEVEL_W = 6;
   localparam int FPB     = 192;
`ifdef SPDIF_SEQ_HOLD_LAST_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst, start, stop, req;
   logic [DATA_W-1:0]  l_data, r_data, sample;
   logic               l_valid, r_valid, l_pop, r_pop;
   logic [LEVEL_W-1:0] l_level, r_level;
   logic               run_en, block_start, underrun;
   logic [7:0]         frame_idx;
   logic [15:0]        underrun_count;

   always #5 clk = ~clk;

   spdif_tx_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .l_data(l_data), .l_valid(l_valid), .l_level(l_level), .l_pop(l_pop),
      .r_data(r_data), .r_valid(r_valid), .r_level(r_level), .r_pop(r_pop),
      .req(req), .sample(sample), .run_en(run_en), .block_start(block_start),
      .frame_idx(frame_idx), .underrun(underrun), .underrun_count(underrun_count)
   );

   logic [DATA_W-1:0] lq[$];
   logic [DATA_W-1:0] rq[$];
   bit                l_starve, r_starve, lvl_ov;
   int                l_lvl_ov, r_lvl_ov;
   int                checks, passes;
   int                n_served;
   bit                stopping;
   int                exp_ucount;
   logic [DATA_W-1:0] last_l, last_r;
   logic [DATA_W+11:0] exp_v, obs_v;  // {sample, l_pop, r_pop, underrun, block_start, frame_idx}
   bit                exp_exit;

   function automatic void update_ifc();
      l_valid = (lq.size() > 0) && !l_starve;
      r_valid = (rq.size() > 0) && !r_starve;
      l_data  = (lq.size() > 0) ? lq[0] : '0;
      r_data  = (rq.size() > 0) ? rq[0] : '0;
      l_level = lvl_ov ? LEVEL_W'(l_lvl_ov) : LEVEL_W'((lq.size() > 63) ? 63 : lq.size());
      r_level = lvl_ov ? LEVEL_W'(r_lvl_ov) : LEVEL_W'((rq.size() > 63) ? 63 : rq.size());
   endfunction

   function automatic void top_up(int k);
      while (lq.size() < k) lq.push_back(DATA_W'($urandom));
      while (rq.size() < k) rq.push_back(DATA_W'($urandom));
      update_ifc();
   endfunction

   function automatic void model_reset();
      n_served   = 0;
      stopping   = 1'b0;
      exp_ucount = 0;
      last_l     = '0;
      last_r     = '0;
   endfunction

   // A pop seen during a cycle removes the FIFO head at the following edge.
   task automatic tick();
      logic pl, pr;
      pl = l_pop;
      pr = r_pop;
      @(posedge clk);
      if (pl === 1'b1 && lq.size() > 0) void'(lq.pop_front());
      if (pr === 1'b1 && rq.size() > 0) void'(rq.pop_front());
      #1;
      update_ifc();
   endtask

   task automatic serve_req();
      bit                is_r, v;
      int                fr;
      logic [DATA_W-1:0] d;
      is_r     = (n_served % 2) == 1;
      fr       = (n_served / 2) % FPB;
      v        = is_r ? r_valid : l_valid;
      d        = is_r ? r_data : l_data;
      exp_exit = stopping && is_r && (fr == FPB - 1);
      if (!v) begin
         d = HOLD_EN ? (is_r ? last_r : last_l) : '0;
         if (exp_ucount < 65535) exp_ucount++;
      end else if (is_r) begin
         last_r = d;
      end else begin
         last_l = d;
      end
      exp_v = {d, v && !is_r, v && is_r, !v, (n_served % (2 * FPB)) == 0,
               exp_exit ? 8'd0 : 8'(fr)};
      req = 1'b1;
      tick();
      req = 1'b0;
      obs_v = {sample, l_pop, r_pop, underrun, block_start, frame_idx};
      n_served = exp_exit ? 0 : n_served + 1;
      if (exp_exit) stopping = 1'b0;
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (run_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; req = 1'b0;
      lvl_ov = 1'b0; l_starve = 1'b0; r_starve = 1'b0;
      model_reset();
      update_ifc();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      obs_v = {sample, l_pop, r_pop, underrun, block_start, frame_idx};
      if (obs_v !== '0) $display("FAIL reset_outputs: got %h want 0", obs_v); else passes++;
      checks++;
      if (run_en !== 1'b0) $display("FAIL reset_run_en: got %b want 0", run_en); else passes++;
      checks++;
      if (underrun_count !== 16'd0) $display("FAIL reset_ucount: got %0d want 0", underrun_count); else passes++;
      checks++;
   endtask

   task automatic test_prefill_gate();
      int bad;
      lvl_ov = 1'b1; l_lvl_ov = 8; r_lvl_ov = 7;
      update_ifc();
      start = 1'b1;
      last_l = '0; last_r = '0;
      tick();
      start = 1'b0;
      bad = 0;
      repeat (20) begin
         tick();
         if (run_en !== 1'b0) bad++;
      end
      if (bad != 0) $display("FAIL prefill_hold: run_en high in %0d cycles, want 0", bad); else passes++;
      checks++;
      r_lvl_ov = 8;
      update_ifc();
      tick();
      if (run_en !== 1'b1) $display("FAIL prefill_release: run_en %b want 1", run_en); else passes++;
      checks++;
      lvl_ov = 1'b0;
      update_ifc();
   endtask

   task automatic test_alternation();
      logic [DATA_W-1:0] tbl_s [4];
      logic [7:0]        tbl_f [4];
      tbl_s[0] = 20'h00001; tbl_s[1] = 20'h80001; tbl_s[2] = 20'h00002; tbl_s[3] = 20'h80002;
      tbl_f[0] = 8'd0; tbl_f[1] = 8'd0; tbl_f[2] = 8'd1; tbl_f[3] = 8'd1;
      lq.push_back(20'h00001); lq.push_back(20'h00002);
      rq.push_back(20'h80001); rq.push_back(20'h80002);
      update_ifc();
      for (int i = 0; i < 4; i++) begin
         serve_req();
         if (obs_v !== exp_v) $display("FAIL alt_req%0d: got %h want %h", i, obs_v, exp_v); else passes++;
         checks++;
         if (sample !== tbl_s[i] || frame_idx !== tbl_f[i] || block_start !== (i == 0))
            $display("FAIL alt_table%0d: sample %h frame %0d bs %b want %h %0d %b",
                     i, sample, frame_idx, block_start, tbl_s[i], tbl_f[i], i == 0);
         else passes++;
         checks++;
      end
      tick();
      if (sample !== 20'h80002 || l_pop !== 1'b0 || r_pop !== 1'b0)
         $display("FAIL alt_hold: sample %h pops %b%b want 80002 00", sample, l_pop, r_pop);
      else passes++;
      checks++;
   endtask

   task automatic test_underrun();
      top_up(3);
      serve_req();
      if (obs_v !== exp_v) $display("FAIL under_lreq: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      r_starve = 1'b1;
      update_ifc();
      serve_req();
      if (obs_v !== exp_v) $display("FAIL under_rreq: got %h want %h", obs_v, exp_v); else passes++;
      checks++;
      if (underrun_count !== 16'(exp_ucount))
         $display("FAIL under_count: got %0d want %0d", underrun_count, exp_ucount);
      else passes++;
      checks++;
      r_starve = 1'b0;
      update_ifc();
      tick();
      if (underrun !== 1'b0) $display("FAIL under_pulse: underrun %b want 0", underrun); else passes++;
      checks++;
   endtask

   task automatic test_block_stop();
      int bad;
      logic [DATA_W-1:0] held;
      while (n_served < 12) begin
         top_up(3);
         if ($urandom_range(0, 1) == 1) tick();
         serve_req();
         if (obs_v !== exp_v) $display("FAIL pre_stop_req%0d: got %h want %h", n_served, obs_v, exp_v); else passes++;
         checks++;
      end
      if (frame_idx !== 8'd5) $display("FAIL stop_at_frame: got %0d want 5", frame_idx); else passes++;
      checks++;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      stopping = 1'b1;
      bad = 0;
      for (int i = 0; i < 372; i++) begin
         top_up(3);
         l_starve = ($urandom_range(0, 15) == 0);
         r_starve = ($urandom_range(0, 15) == 0);
         update_ifc();
         if ($urandom_range(0, 2) == 0) tick();
         serve_req();
         if (obs_v !== exp_v) $display("FAIL stop_req%0d: got %h want %h", i, obs_v, exp_v); else passes++;
         checks++;
         if (i < 371 && run_en !== 1'b1) bad++;
      end
      l_starve = 1'b0; r_starve = 1'b0;
      update_ifc();
      if (bad != 0) $display("FAIL stop_run_en_held: dropped in %0d reqs, want 0", bad); else passes++;
      checks++;
      if (run_en !== 1'b0 || frame_idx !== 8'd0)
         $display("FAIL stop_exit: run_en %b frame %0d want 0 0", run_en, frame_idx);
      else passes++;
      checks++;
      if (underrun_count !== 16'(exp_ucount))
         $display("FAIL stop_ucount: got %0d want %0d", underrun_count, exp_ucount);
      else passes++;
      checks++;
      held = sample;
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      if (l_pop !== 1'b0 || r_pop !== 1'b0 || sample !== held)
         $display("FAIL idle_req_ignored: pops %b%b sample %h want 00 %h", l_pop, r_pop, sample, held);
      else passes++;
      checks++;
   endtask

   task automatic test_wrap();
      bit ok;
      top_up(10);
      start = 1'b1;
      last_l = '0; last_r = '0;
      tick();
      start = 1'b0;
      wait_run(ok);
      if (!ok) $display("FAIL wrap_start: run_en %b want 1 within 20 cycles", run_en); else passes++;
      checks++;
      for (int i = 0; i < 385; i++) begin
         top_up(4);
         serve_req();
         if (obs_v !== exp_v) $display("FAIL wrap_req%0d: got %h want %h", i, obs_v, exp_v); else passes++;
         checks++;
         if (i == 383) begin
            if (frame_idx !== 8'd191) $display("FAIL wrap_last_frame: got %0d want 191", frame_idx); else passes++;
            checks++;
         end
      end
      if (block_start !== 1'b1 || frame_idx !== 8'd0)
         $display("FAIL wrap_block_start: bs %b frame %0d want 1 0", block_start, frame_idx);
      else passes++;
      checks++;
   endtask

   task automatic test_collisions();
      bit ok;
      top_up(4);
      req = 1'b1;
      rst = 1'b1;
      tick();
      req = 1'b0;
      rst = 1'b0;
      model_reset();
      obs_v = {sample, l_pop, r_pop, underrun, block_start, frame_idx};
      if (obs_v !== '0 || run_en !== 1'b0 || underrun_count !== 16'd0)
         $display("FAIL rst_mid_run: outs %h run_en %b ucount %0d want 0 0 0", obs_v, run_en, underrun_count);
      else passes++;
      checks++;
      tick();
      lvl_ov = 1'b1; l_lvl_ov = 20; r_lvl_ov = 20;
      start = 1'b1; stop = 1'b1;
      update_ifc();
      tick();
      start = 1'b0; stop = 1'b0;
      repeat (5) tick();
      if (run_en !== 1'b0) $display("FAIL start_stop_same: run_en %b want 0", run_en); else passes++;
      checks++;
      l_lvl_ov = 3; r_lvl_ov = 3;
      update_ifc();
      start = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      l_lvl_ov = 20; r_lvl_ov = 20;
      update_ifc();
      repeat (5) tick();
      if (run_en !== 1'b0) $display("FAIL stop_in_prefill: run_en %b want 0", run_en); else passes++;
      checks++;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_run(ok);
      if (!ok) $display("FAIL restart: run_en %b want 1 within 20 cycles", run_en); else passes++;
      checks++;
      lvl_ov = 1'b0;
      update_ifc();
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_prefill_gate();
      test_alternation();
      test_underrun();
      test_block_stop();
      test_wrap();
      test_collisions();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
